// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer fronting a NUM_REGS x 32-bit register file.
//
// Each transfer is accepted in the setup phase. The completer then inserts
// wait_cfg + 1 wait states, asserts a registered pready for exactly one cycle
// and returns to idle. Register 0 is a read-only ID word. Bad accesses complete
// with pslverr set and leave the register file untouched.
//
// Ports
//   pclk, presetn   clock (rising edge) and asynchronous active-low reset
//   psel, penable   APB select and access-phase strobes
//   pwrite          1 = write, 0 = read
//   paddr, pwdata   byte address and write data
//   wait_cfg        extra wait states, sampled in the setup phase only
//   pready          transfer complete, high for one cycle
//   prdata, pslverr read data and error, both zero whenever pready is low
//   regs_q          flat register contents, reg i on bits [32*i+31:32*i]
module apb_slave_regfile #(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = 16'h0000,
    parameter logic [DATA_W-1:0]    ID_VALUE  = 32'hA5B0_0001
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
    input  logic [2:0]                 wait_cfg,
    output logic                       pready,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pslverr,
    output logic [NUM_REGS*DATA_W-1:0] regs_q
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pready_d;
    logic [DATA_W-1:0]   prdata_d;
    logic                pslverr_d;
    logic                wr_en;

    // Register 0 is the constant ID word, so storage starts at index 1.
    logic [NUM_REGS-1:1][DATA_W-1:0] regs_r;

    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   idx;
    logic                access_err;
    logic [DATA_W-1:0]   rd_val;

    // Decode always works on the address latched in the setup phase.
    always_comb begin
        offset     = addr_q - BASE_ADDR;
        idx        = offset >> 2;
        access_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                     (idx >= ADDR_W'(NUM_REGS)) ||
                     (write_q && (idx == '0));
    end

    always_comb begin
        rd_val = ID_VALUE;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (idx == ADDR_W'(i)) begin
                rd_val = regs_r[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        wr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // An access phase with no preceding setup is ignored.
                if (psel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    cnt_d   = wait_cfg;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!psel) begin
                    // Master abort: drop the transfer without committing.
                    state_d = StIdle;
                end else if (penable) begin
                    if (cnt_q != 3'd0) begin
                        cnt_d = cnt_q - 3'd1;
                    end else begin
                        pready_d = 1'b1;
                        state_d  = StDone;
                        if (access_err) begin
                            pslverr_d = 1'b1;
                        end else if (write_q) begin
                            wr_en = 1'b1;
                        end else begin
                            prdata_d = rd_val;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            pready  <= pready_d;
            prdata  <= prdata_d;
            pslverr <= pslverr_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            regs_r <= '0;
        end else if (wr_en) begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                if (idx == ADDR_W'(i)) begin
                    regs_r[i] <= wdata_q;
                end
            end
        end
    end

    assign regs_q[DATA_W-1:0] = ID_VALUE;
    for (genvar g = 1; g < int'(NUM_REGS); g++) begin : g_regs_out
        assign regs_q[g*DATA_W +: DATA_W] = regs_r[g];
    end

endmodule
